// File: rtl/level_hold_out.sv
// -----------------------------------------------------------------------------
// level_hold_out
//
// Rate-limited level output. A requester asks for a new output level through a
// valid/ready handshake. When the requested level differs from the current
// pin_out, pin_out takes the new level at the next rising edge. The block then
// holds that level for 2^BITS cycles in HOLD before it looks at another change.
// Each change of pin_out gives a one-cycle toggled pulse and increments a
// wrapping 16-bit toggle counter.
//
// Optional feature (compile-time macro LEVEL_HOLD_PENDING_EN):
//   A one-deep pending-request register (pend_valid, pend_level) is added.
//   Requests are also accepted during HOLD, and the newest one wins. When the
//   hold expires, the effective request (a live in_valid overrides the pending
//   one) is applied at that same edge if it differs from pin_out. In that case
//   the block stays in HOLD for another full period, so no idle cycle is
//   inserted between level changes.
//   Without the macro, in_ready is low during HOLD and requests made then are
//   ignored.
//
// Parameters
//   BITS          hold-counter width, 2..16; HOLD lasts 2^BITS cycles
//
// Ports
//   clk           clock, all logic on rising edge
//   rst           synchronous, active-high reset
//   in_valid      level-change request strobe
//   in_level      requested output level
//   in_ready      request accepted when in_valid && in_ready (0 during rst)
//   pin_out       registered, rate-limited output level
//   busy          high while in HOLD
//   toggled       one-cycle registered pulse in the first cycle of a new level
//   toggle_count  number of pin_out changes, modulo 2^16
// -----------------------------------------------------------------------------
module level_hold_out #(
  parameter int BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_level,
  output logic        in_ready,
  output logic        pin_out,
  output logic        busy,
  output logic        toggled,
  output logic [15:0] toggle_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [BITS-1:0]   hold_cnt, hold_cnt_nxt;
  logic              pin_nxt;
  logic              toggled_nxt;
  logic [15:0]       count_nxt;
  logic              hold_done;

`ifdef LEVEL_HOLD_PENDING_EN
  logic              pend_valid, pend_valid_nxt;
  logic              pend_level, pend_level_nxt;
  logic              eff_valid;
  logic              eff_level;
`endif

  // The hold ends at the edge that closes the cycle where the counter reads
  // all ones. Counting from 0, that gives exactly 2^BITS cycles in HOLD.
  assign hold_done = (hold_cnt == {BITS{1'b1}});
  assign busy      = (state == HOLD);

`ifdef LEVEL_HOLD_PENDING_EN
  // A live request at the expiry edge is newer than anything in pending.
  assign eff_valid = in_valid | pend_valid;
  assign eff_level = in_valid ? in_level : pend_level;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    pin_nxt      = pin_out;
    toggled_nxt  = 1'b0;
    count_nxt    = toggle_count;
    in_ready     = 1'b0;
`ifdef LEVEL_HOLD_PENDING_EN
    pend_valid_nxt = pend_valid;
    pend_level_nxt = pend_level;
`endif

    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        // A request for the level already on the pin is consumed and does
        // nothing.
        if (in_valid && (in_level != pin_out)) begin
          pin_nxt      = in_level;
          toggled_nxt  = 1'b1;
          count_nxt    = toggle_count + 16'd1;
          hold_cnt_nxt = '0;
          state_nxt    = HOLD;
        end
      end

      HOLD: begin
        hold_cnt_nxt = hold_cnt + 1'b1;
`ifdef LEVEL_HOLD_PENDING_EN
        in_ready = ~rst;
        if (hold_done) begin
          // Pending is used once at expiry and then always cleared.
          pend_valid_nxt = 1'b0;
          if (eff_valid && (eff_level != pin_out)) begin
            // Restart the hold at the same edge. The new level then lasts
            // exactly 2^BITS cycles.
            pin_nxt      = eff_level;
            toggled_nxt  = 1'b1;
            count_nxt    = toggle_count + 16'd1;
            hold_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (in_valid) begin
          pend_valid_nxt = 1'b1;
          pend_level_nxt = in_level;
        end
`else
        if (hold_done) begin
          state_nxt = IDLE;
        end
`endif
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its old value at the edge, whatever order the statements
  // appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      pin_out      <= 1'b0;
      toggled      <= 1'b0;
      toggle_count <= 16'd0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      pin_out      <= pin_nxt;
      toggled      <= toggled_nxt;
      toggle_count <= count_nxt;
    end
  end

`ifdef LEVEL_HOLD_PENDING_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_level <= 1'b0;
    end else begin
      pend_valid <= pend_valid_nxt;
      pend_level <= pend_level_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_level_hold_out.sv
// -----------------------------------------------------------------------------
// tb_level_hold_out
//
// Directed, table-driven bench for level_hold_out with BITS=4 (16-cycle hold).
// Each table row drives rst/in_valid/in_level for 'reps' cycles. In every one
// of those cycles it compares the outputs against hand-computed values.
// The table content depends on whether LEVEL_HOLD_PENDING_EN is defined.
// Afterwards, a hand-written sequence checks the 65535 -> 0 wrap of
// toggle_count.
// -----------------------------------------------------------------------------
module tb_level_hold_out;

  localparam int BITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_level;
  logic        in_ready;
  logic        pin_out;
  logic        busy;
  logic        toggled;
  logic [15:0] toggle_count;

  int n_vec  = 0;
  int n_miss = 0;

  level_hold_out #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_level     (in_level),
    .in_ready     (in_ready),
    .pin_out      (pin_out),
    .busy         (busy),
    .toggled      (toggled),
    .toggle_count (toggle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        level;
    int          reps;
    logic        pin;
    logic        tog;
    logic        busy;
    logic        ready;
    logic [15:0] cnt;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic l, int n,
                              logic p, logic t, logic b, logic rd,
                              logic [15:0] c, string nm);
    vec_t x;
    x.rst = r; x.valid = v; x.level = l; x.reps = n;
    x.pin = p; x.tog = t; x.busy = b; x.ready = rd; x.cnt = c; x.name = nm;
    return x;
  endfunction

  task automatic check(string name, logic [19:0] act, logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got pin/tog/busy/rdy=%b%b%b%b cnt=%0d, want %b%b%b%b cnt=%0d",
               name, act[19], act[18], act[17], act[16], act[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Drive inputs after the falling edge and let them settle. Then compare the
  // outputs for this cycle, before the next rising edge.
  task automatic drive(logic r, logic v, logic l);
    @(negedge clk);
    rst = r; in_valid = v; in_level = l;
    #1;
  endtask

  function automatic logic [19:0] outs();
    return {pin_out, toggled, busy, in_ready, toggle_count};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_level = 1'b0;
    @(posedge clk);

    // Reset row. Reset holds priority over a simultaneous request, and
    // in_ready is 0 while rst is high.
    tbl.push_back(mk(1, 1, 1,  1,  0, 0, 0, 0, 16'd0, "reset_prio"));
    // Cycle 0: request level 1 from IDLE.
    tbl.push_back(mk(0, 1, 1,  1,  0, 0, 0, 1, 16'd0, "c0_req1"));
`ifndef LEVEL_HOLD_PENDING_EN
    tbl.push_back(mk(0, 0, 0,  1,  1, 1, 1, 0, 16'd1, "c1_rise"));
    tbl.push_back(mk(0, 0, 0,  3,  1, 0, 1, 0, 16'd1, "c2_4_hold"));
    tbl.push_back(mk(0, 1, 0,  1,  1, 0, 1, 0, 16'd1, "c5_req_ignored"));
    tbl.push_back(mk(0, 0, 0, 11,  1, 0, 1, 0, 16'd1, "c6_16_hold"));
    tbl.push_back(mk(0, 1, 0,  1,  1, 0, 0, 1, 16'd1, "c17_idle_req0"));
    tbl.push_back(mk(0, 0, 0,  1,  0, 1, 1, 0, 16'd2, "c18_fall"));
    tbl.push_back(mk(0, 0, 0, 15,  0, 0, 1, 0, 16'd2, "c19_33_hold"));
    tbl.push_back(mk(0, 1, 0,  1,  0, 0, 0, 1, 16'd2, "c34_equal_req"));
    tbl.push_back(mk(0, 0, 0,  1,  0, 0, 0, 1, 16'd2, "c35_no_toggle"));
    tbl.push_back(mk(0, 1, 1,  1,  0, 0, 0, 1, 16'd2, "c36_req1"));
    tbl.push_back(mk(0, 0, 0,  1,  1, 1, 1, 0, 16'd3, "c37_rise"));
    tbl.push_back(mk(0, 0, 0,  6,  1, 0, 1, 0, 16'd3, "c38_43_hold"));
    tbl.push_back(mk(1, 1, 0,  1,  1, 0, 1, 0, 16'd3, "c44_rst_midhold"));
    tbl.push_back(mk(0, 0, 0,  2,  0, 0, 0, 1, 16'd0, "c45_after_rst"));
`else
    tbl.push_back(mk(0, 0, 0,  1,  1, 1, 1, 1, 16'd1, "c1_rise"));
    tbl.push_back(mk(0, 0, 0,  2,  1, 0, 1, 1, 16'd1, "c2_3_hold"));
    tbl.push_back(mk(0, 1, 0,  1,  1, 0, 1, 1, 16'd1, "c4_pend0"));
    tbl.push_back(mk(0, 0, 0, 12,  1, 0, 1, 1, 16'd1, "c5_16_hold"));
    tbl.push_back(mk(0, 0, 0,  1,  0, 1, 1, 1, 16'd2, "c17_pend_apply"));
    tbl.push_back(mk(0, 0, 0,  2,  0, 0, 1, 1, 16'd2, "c18_19_hold"));
    tbl.push_back(mk(0, 1, 1,  1,  0, 0, 1, 1, 16'd2, "c20_pend1"));
    tbl.push_back(mk(0, 0, 0,  3,  0, 0, 1, 1, 16'd2, "c21_23_hold"));
    tbl.push_back(mk(0, 1, 0,  1,  0, 0, 1, 1, 16'd2, "c24_pend0_wins"));
    tbl.push_back(mk(0, 0, 0,  8,  0, 0, 1, 1, 16'd2, "c25_32_hold"));
    tbl.push_back(mk(0, 0, 0,  2,  0, 0, 0, 1, 16'd2, "c33_34_idle"));
    tbl.push_back(mk(0, 1, 1,  1,  0, 0, 0, 1, 16'd2, "c35_req1"));
    tbl.push_back(mk(0, 0, 0,  1,  1, 1, 1, 1, 16'd3, "c36_rise"));
    tbl.push_back(mk(0, 0, 0, 14,  1, 0, 1, 1, 16'd3, "c37_50_hold"));
    tbl.push_back(mk(0, 1, 0,  1,  1, 0, 1, 1, 16'd3, "c51_live_at_expiry"));
    tbl.push_back(mk(0, 0, 0,  1,  0, 1, 1, 1, 16'd4, "c52_fall"));
    tbl.push_back(mk(0, 1, 1,  1,  0, 0, 1, 1, 16'd4, "c53_pend1"));
    tbl.push_back(mk(1, 0, 0,  1,  0, 0, 1, 0, 16'd4, "c54_rst_midhold"));
    tbl.push_back(mk(0, 0, 0, 20,  0, 0, 0, 1, 16'd0, "c55_after_rst"));
`endif

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        drive(tbl[i].rst, tbl[i].valid, tbl[i].level);
        check(tbl[i].name, outs(),
              {tbl[i].pin, tbl[i].tog, tbl[i].busy, tbl[i].ready, tbl[i].cnt});
      end
    end

    // Counter wrap: preload 65535 while IDLE with pin_out=0, then make one change.
    @(negedge clk);
    force dut.toggle_count = 16'hFFFF;
    #1;
    release dut.toggle_count;
    drive(0, 1, 1);
    check("wrap_preload", outs(), {1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF});
    drive(0, 0, 0);
    check("wrap_to_zero", outs(), {1'b1, 1'b1, 1'b1, 1'b0 | busy_ready_en(), 16'd0});
    drive(0, 0, 0);
    check("wrap_pulse_end", outs(), {1'b1, 1'b0, 1'b1, 1'b0 | busy_ready_en(), 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // in_ready during HOLD is 1 only with the pending register compiled in.
  function automatic logic busy_ready_en();
`ifdef LEVEL_HOLD_PENDING_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

endmodule

// File: doc/level_hold_out.md
LEVEL_HOLD_OUT -- requirements
Module: level_hold_out

Interface
REQ-001 SHALL have parameter BITS, default 8, hold-counter width (legal range 2..16); minimum hold is 2^BITS cycles.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  level-change request strobe.
REQ-005 SHALL have port in_level  input  1  requested output level.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port pin_out  output  1  registered, rate-limited output level.
REQ-008 SHALL have port busy  output  1  high while in HOLD.
REQ-009 SHALL have port toggled  output  1  one-cycle registered pulse on each pin_out change.
REQ-010 SHALL have port toggle_count  output  16  count of pin_out changes, wraps 65535 -> 0.

Function
REQ-011 SHALL implement two states: IDLE, HOLD; busy = (state == HOLD).
REQ-012 IDLE: in_ready = 1; accepted request with in_level != pin_out SHALL set pin_out = in_level at the next edge, clear hold counter to 0, enter HOLD, assert toggled, increment toggle_count.
REQ-013 IDLE: accepted request with in_level == pin_out SHALL be consumed with no change; state stays IDLE, toggled stays 0.
REQ-014 Latency accepted request -> pin_out change SHALL be exactly 1 cycle.
REQ-015 HOLD: hold counter SHALL increment by 1 each cycle from 0; at the edge ending the cycle where counter == 2^BITS-1, hold SHALL expire (HOLD lasts exactly 2^BITS cycles).
REQ-016 Without the configured feature, expiry SHALL return to IDLE; pin_out minimum level duration SHALL be 2^BITS+1 cycles.
REQ-017 toggled SHALL be high exactly in the first cycle pin_out shows its new value, and low otherwise.
REQ-018 toggle_count SHALL be unsigned 16-bit, modulo 2^16, updated in the same edge as pin_out.
REQ-019 pin_out SHALL never change except via REQ-012 or REQ-026; no combinational path from in_level to pin_out.

Reset
REQ-020 rst SHALL, at the next edge and in any state (including mid-HOLD), set pin_out=0, state=IDLE, hold counter=0, toggled=0, toggle_count=0, pending cleared.
REQ-021 rst SHALL take priority over any simultaneous in_valid; no toggled pulse results from reset.
REQ-022 in_ready SHALL be 0 while rst is high.

Configuration
REQ-023 Macro LEVEL_HOLD_PENDING_EN SHALL compile in a one-deep pending-request register (pend_valid, pend_level).
REQ-024 Without LEVEL_HOLD_PENDING_EN: in_ready = 0 in HOLD; in_valid during HOLD SHALL have no effect.
REQ-025 With LEVEL_HOLD_PENDING_EN: in_ready = 1 in HOLD; each accepted request SHALL overwrite pending (latest wins).
REQ-026 With LEVEL_HOLD_PENDING_EN, at expiry the effective request (in_valid ? in_level : pend_level, valid if in_valid || pend_valid) SHALL be evaluated: if valid and != pin_out -> pin_out changes at that same edge, counter 0, remain HOLD, toggled, count++; else -> IDLE; pending SHALL clear in both cases.
REQ-027 With LEVEL_HOLD_PENDING_EN, minimum pin_out level duration SHALL be exactly 2^BITS cycles.

Verification (BITS=4, hold 16 cycles)
REQ-028 Reset, in_valid=1/in_level=1 at cycle 0 -> pin_out=1 and toggled=1 at cycle 1, busy high cycles 1..16, toggle_count=1, in_ready=1 at cycle 17.
REQ-029 No EN: request level 0 at HOLD cycle 5 -> in_ready=0, pin_out stays 1; request 0 at cycle 17 -> pin_out=0 at cycle 18, toggle_count=2.
REQ-030 EN: pin_out rises cycle 1, request 0 at cycle 4 -> pin_out=0 at cycle 17 (16-cycle level), toggled at 17, busy stays high.
REQ-031 EN: during HOLD request 0 at cycle 3 then 1 at cycle 7 (pin_out=1) -> no change at expiry, IDLE at cycle 17, toggle_count unchanged.
REQ-032 IDLE, request equal to pin_out -> no toggled, busy stays 0; rst at HOLD cycle 8 -> next cycle pin_out=0, busy=0, toggle_count=0, no toggled.
REQ-033 Preload 65535 toggles (or force) then one change -> toggle_count=0, toggled=1.
